id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register plus EX operand selection for the 5-stage MIPS core.
//   Captures decoded controls and operands from ID, forwards MEM/WB results, and drives ALU A/B/ALUControl.
//   Detects load-use hazards against the instruction it holds and reports them to the ID stage.
// PARAMETERS
//   DATA_W  32  datapath width
//   REG_AW  5   register-file address width
//   CTRL_W  4   ALUControl width
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous, active-high reset
//   Hold           in   1       freeze whole EX/MEM/WB pipe (memory wait)
//   Flush          in   1       load a bubble (branch redirect or load-use)
//   ID_Valid       in   1       ID holds a real instruction
//   ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_IsShift, ID_UsesRt  in 1  decoded controls
//   ID_ALUControl  in   CTRL_W  ALU op
//   ID_ReadData1   in   DATA_W  rs value from register file
//   ID_ReadData2   in   DATA_W  rt value from register file
//   ID_Imm         in   DATA_W  sign-extended immediate
//   ID_Rs, ID_Rt, ID_Rd  in  REG_AW  register specifiers
//   ID_Shamt       in   5       shift amount
//   MEM_RegWrite   in   1       / MEM_Rd in REG_AW / MEM_ALUResult in DATA_W : EX/MEM forward source
//   WB_RegWrite    in   1       / WB_Rd in REG_AW / WB_Data in DATA_W : MEM/WB forward source
//   ALU_A, ALU_B   out  DATA_W  ALU operands
//   ALUControl     out  CTRL_W  registered ALU op
//   EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg  out 1  registered controls
//   EX_WriteReg    out  REG_AW  destination (Rd if RegDst else Rt)
//   EX_StoreData   out  DATA_W  forwarded rt value for stores
//   LoadUseHazard  out  1       combinational; ID must stall and assert Flush
// BEHAVIOUR
//   - Reset: every register 0 -> EX_Valid=0, all controls 0, ALUControl=0000, EX_WriteReg=0; ALU_A/ALU_B/EX_StoreData
//     then equal forwarded zeros.
//   - Update priority each edge: Flush > Hold > load. Flush: Valid and all controls cleared, data fields don't-care (zeroed).
//     Hold: all fields keep value. Else capture ID_* (Valid=ID_Valid; controls gated to 0 when ID_Valid=0).
//   - Latency: ID values appear on outputs 1 cycle after capture edge; forwarding is combinational in EX.
//   - Forward per operand (rs, rt): MEM if MEM_RegWrite & MEM_Rd!=0 & MEM_Rd==reg; else WB if WB_RegWrite &
//     WB_Rd!=0 & WB_Rd==reg; else registered read data. MEM strictly beats WB. $0 never forwarded.
//   - ALU_A = IsShift ? fwd_rt : fwd_rs.
//   - ALU_B = IsShift ? {27'b0,Shamt} : ALUSrc ? Imm : fwd_rt.  EX_StoreData = fwd_rt always.
//   - LoadUseHazard = EX_Valid & EX_MemRead & EX_WriteReg!=0 & ID_Valid & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
//   - Hold applies pipe-wide, so MEM/WB forward sources are stable while held; no internal re-capture.
//   - Register file is write-before-read; no WB bypass on ID_ReadData*.
//   - Reset mid-operation: immediate bubble, LoadUseHazard drops same cycle.
// STRUCTURE
//   - mips_pkg: ALU op constants (ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100,
//     ALU_SLL=1000, ALU_SRL=1001), FWD_REG/FWD_MEM/FWD_WB select encodings, REG_ZERO.
//   - Sub-module fwd_select (one instance per operand): takes reg index, MEM/WB sources, register value; returns
//     forwarded data. Pipeline register and hazard logic stay in id_ex_stage.
// TESTING
//   - Reset asserted mid-run with EX_Valid=1 -> EX_Valid=0, EX_RegWrite=0, ALUControl=0000 immediately, before any clk edge.
//   - ADD, rs=$8(5), rt=$9(7), MEM_Rd=8 MEM_ALUResult=100, WB_Rd=8 WB_Data=200 -> ALU_A=100 (MEM wins), ALU_B=7.
//   - WB_Rd=0, WB_RegWrite=1, WB_Data=0xFFFF, rs=$0 -> ALU_A=ID_ReadData1 (0), no forward.
//   - SLL rt=$3(0x1), Shamt=4 -> ALU_A=0x1, ALU_B=4; ALUControl=1000 one cycle after capture.
//   - EX holds LW to $5; ID presents ADD rs=$5 -> LoadUseHazard=1; Flush next edge -> EX_Valid=0, MemRead=0, hazard=0.
//   - Hold=1 for 3 cycles with changing ID_* -> all EX_* stable; Hold=1&Flush=1 same edge -> bubble loaded.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU op codes, forward-select encodings and register constants
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forwarding mux: MEM result beats WB data beats register value
module fwd_select
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] reg_idx_i,
    input  logic              mem_regwrite_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              wb_regwrite_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    fwd_sel_e sel;
    logic     mem_hit;
    logic     wb_hit;

    // $0 is hard-wired, so a write to it must never be forwarded
    assign mem_hit = mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == reg_idx_i);
    assign wb_hit  = wb_regwrite_i  && (wb_rd_i  != '0) && (wb_rd_i  == reg_idx_i);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        fwd_data_o = reg_data_i;
        case (sel)
            FWD_MEM: fwd_data_o = mem_data_i;
            FWD_WB:  fwd_data_o = wb_data_i;
            default: fwd_data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register, EX operand forwarding/selection and load-use detection
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Hold,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic              ID_IsShift,
    input  logic              ID_UsesRt,
    input  logic [CTRL_W-1:0] ID_ALUControl,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic [4:0]        ID_Shamt,
    input  logic              MEM_RegWrite,
    input  logic [REG_AW-1:0] MEM_Rd,
    input  logic [DATA_W-1:0] MEM_ALUResult,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_Rd,
    input  logic [DATA_W-1:0] WB_Data,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemtoReg,
    output logic [REG_AW-1:0] EX_WriteReg,
    output logic [DATA_W-1:0] EX_StoreData,
    output logic              LoadUseHazard
);

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic              memwrite_q, memwrite_d;
    logic              memtoreg_q, memtoreg_d;
    logic              alusrc_q,   alusrc_d;
    logic              isshift_q,  isshift_d;
    logic [CTRL_W-1:0] aluctl_q,   aluctl_d;
    logic [REG_AW-1:0] writereg_q, writereg_d;
    logic [REG_AW-1:0] rs_q,       rs_d;
    logic [REG_AW-1:0] rt_q,       rt_d;
    logic [DATA_W-1:0] rd1_q,      rd1_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [4:0]        shamt_q,    shamt_d;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Priority: Flush loads a fully zeroed bubble, Hold keeps everything, else capture ID
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        isshift_d  = isshift_q;
        aluctl_d   = aluctl_q;
        writereg_d = writereg_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        if (Flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alusrc_d   = 1'b0;
            isshift_d  = 1'b0;
            aluctl_d   = '0;
            writereg_d = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            shamt_d    = '0;
        end else if (!Hold) begin
            valid_d    = ID_Valid;
            regwrite_d = ID_Valid & ID_RegWrite;
            memread_d  = ID_Valid & ID_MemRead;
            memwrite_d = ID_Valid & ID_MemWrite;
            memtoreg_d = ID_Valid & ID_MemtoReg;
            alusrc_d   = ID_Valid & ID_ALUSrc;
            isshift_d  = ID_Valid & ID_IsShift;
            aluctl_d   = ID_Valid ? ID_ALUControl : '0;
            writereg_d = (ID_Valid & ID_RegDst) ? ID_Rd : ID_Rt;
            rs_d       = ID_Rs;
            rt_d       = ID_Rt;
            rd1_d      = ID_ReadData1;
            rd2_d      = ID_ReadData2;
            imm_d      = ID_Imm;
            shamt_d    = ID_Shamt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            isshift_q  <= 1'b0;
            aluctl_q   <= '0;
            writereg_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            isshift_q  <= isshift_d;
            aluctl_q   <= aluctl_d;
            writereg_q <= writereg_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
        end
    end

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .reg_idx_i      (rs_q),
        .mem_regwrite_i (MEM_RegWrite),
        .mem_rd_i       (MEM_Rd),
        .mem_data_i     (MEM_ALUResult),
        .wb_regwrite_i  (WB_RegWrite),
        .wb_rd_i        (WB_Rd),
        .wb_data_i      (WB_Data),
        .reg_data_i     (rd1_q),
        .fwd_data_o     (fwd_rs)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .reg_idx_i      (rt_q),
        .mem_regwrite_i (MEM_RegWrite),
        .mem_rd_i       (MEM_Rd),
        .mem_data_i     (MEM_ALUResult),
        .wb_regwrite_i  (WB_RegWrite),
        .wb_rd_i        (WB_Rd),
        .wb_data_i      (WB_Data),
        .reg_data_i     (rd2_q),
        .fwd_data_o     (fwd_rt)
    );

    // Shifts take their operand from rt and the amount from the shamt field
    assign ALU_A        = isshift_q ? fwd_rt : fwd_rs;
    assign ALU_B        = isshift_q ? {{(DATA_W-5){1'b0}}, shamt_q}
                        : alusrc_q  ? imm_q : fwd_rt;
    assign EX_StoreData = fwd_rt;

    assign ALUControl  = aluctl_q;
    assign EX_Valid    = valid_q;
    assign EX_RegWrite = regwrite_q;
    assign EX_MemRead  = memread_q;
    assign EX_MemWrite = memwrite_q;
    assign EX_MemtoReg = memtoreg_q;
    assign EX_WriteReg = writereg_q;

    assign LoadUseHazard = valid_q & memread_q & (writereg_q != '0) & ID_Valid &
                           ((writereg_q == ID_Rs) | (ID_UsesRt & (writereg_q == ID_Rt)));

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    import mips_pkg::*;

    typedef struct {
        logic        valid, regwrite, memread, memwrite, memtoreg;
        logic        alusrc, regdst, isshift, usesrt;
        logic [3:0]  aluctl;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } stim_t;

    typedef struct {
        logic        valid, regwrite, memread, memwrite, memtoreg;
        logic [3:0]  aluctl;
        logic [4:0]  wr;
        logic [31:0] a, b, sd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, Hold, Flush;
    logic        ID_Valid, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg;
    logic        ID_ALUSrc, ID_RegDst, ID_IsShift, ID_UsesRt;
    logic [3:0]  ID_ALUControl;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
    logic        MEM_RegWrite, WB_RegWrite;
    logic [4:0]  MEM_Rd, WB_Rd;
    logic [31:0] MEM_ALUResult, WB_Data;
    logic [31:0] ALU_A, ALU_B, EX_StoreData;
    logic [3:0]  ALUControl;
    logic        EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg;
    logic [4:0]  EX_WriteReg;
    logic        LoadUseHazard;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    exp_t last_exp;
    stim_t cur;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .Hold(Hold), .Flush(Flush),
        .ID_Valid(ID_Valid), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc),
        .ID_RegDst(ID_RegDst), .ID_IsShift(ID_IsShift), .ID_UsesRt(ID_UsesRt),
        .ID_ALUControl(ID_ALUControl), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
        .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Shamt(ID_Shamt),
        .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd), .MEM_ALUResult(MEM_ALUResult),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_Data(WB_Data),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALUControl(ALUControl),
        .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg), .EX_WriteReg(EX_WriteReg),
        .EX_StoreData(EX_StoreData), .LoadUseHazard(LoadUseHazard)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic stim_t blank();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] v, input stim_t s);
        if (s.mem_rw && s.mem_rd != 0 && s.mem_rd == idx) return s.mem_res;
        if (s.wb_rw && s.wb_rd != 0 && s.wb_rd == idx) return s.wb_data;
        return v;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [31:0] frs, frt;
        frs = fwd(s.rs, s.rd1, s);
        frt = fwd(s.rt, s.rd2, s);
        e.valid    = s.valid;
        e.regwrite = s.valid & s.regwrite;
        e.memread  = s.valid & s.memread;
        e.memwrite = s.valid & s.memwrite;
        e.memtoreg = s.valid & s.memtoreg;
        e.aluctl   = s.valid ? s.aluctl : 4'b0000;
        e.wr       = (s.valid & s.regdst) ? s.rd : s.rt;
        e.a        = (s.valid & s.isshift) ? frt : frs;
        e.b        = (s.valid & s.isshift) ? {27'b0, s.shamt} : (s.valid & s.alusrc) ? s.imm : frt;
        e.sd       = frt;
        return e;
    endfunction

    function automatic logic hazard(input exp_t e, input stim_t s);
        return e.valid & e.memread & (e.wr != 0) & s.valid &
               ((e.wr == s.rs) | (s.usesrt & (e.wr == s.rt)));
    endfunction

    task automatic apply(input stim_t s);
        ID_Valid = s.valid; ID_RegWrite = s.regwrite; ID_MemRead = s.memread;
        ID_MemWrite = s.memwrite; ID_MemtoReg = s.memtoreg; ID_ALUSrc = s.alusrc;
        ID_RegDst = s.regdst; ID_IsShift = s.isshift; ID_UsesRt = s.usesrt;
        ID_ALUControl = s.aluctl; ID_ReadData1 = s.rd1; ID_ReadData2 = s.rd2; ID_Imm = s.imm;
        ID_Rs = s.rs; ID_Rt = s.rt; ID_Rd = s.rd; ID_Shamt = s.shamt;
        MEM_RegWrite = s.mem_rw; MEM_Rd = s.mem_rd; MEM_ALUResult = s.mem_res;
        WB_RegWrite = s.wb_rw; WB_Rd = s.wb_rd; WB_Data = s.wb_data;
    endtask

    // Drive one cycle, push the expected EX state, then pop and compare after the edge
    task automatic step(input stim_t s, input logic hold, input logic flush);
        exp_t e;
        apply(s);
        Hold = hold;
        Flush = flush;
        if (flush) e = '{default: '0};
        else if (hold) e = last_exp;
        else e = model(s);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("valid", {31'b0, EX_Valid}, {31'b0, e.valid});
        check("regwrite", {31'b0, EX_RegWrite}, {31'b0, e.regwrite});
        check("memread", {31'b0, EX_MemRead}, {31'b0, e.memread});
        check("memwrite", {31'b0, EX_MemWrite}, {31'b0, e.memwrite});
        check("memtoreg", {31'b0, EX_MemtoReg}, {31'b0, e.memtoreg});
        check("aluctl", {28'b0, ALUControl}, {28'b0, e.aluctl});
        check("writereg", {27'b0, EX_WriteReg}, {27'b0, e.wr});
        check("alu_a", ALU_A, e.a);
        check("alu_b", ALU_B, e.b);
        check("storedata", EX_StoreData, e.sd);
        check("hazard", {31'b0, LoadUseHazard}, {31'b0, hazard(e, s)});
        last_exp = e;
        cur = s;
    endtask

    initial begin
        stim_t s;
        reset = 1'b1;
        Hold = 1'b0;
        Flush = 1'b0;
        apply(blank());
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, EX_Valid}, 32'd0);
        check("rst_aluctl", {28'b0, ALUControl}, 32'd0);
        check("rst_writereg", {27'b0, EX_WriteReg}, 32'd0);
        check("rst_alu_a", ALU_A, 32'd0);
        check("rst_alu_b", ALU_B, 32'd0);
        check("rst_storedata", EX_StoreData, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD with both MEM and WB matching rs: MEM must win
        s = blank();
        s.valid = 1; s.regwrite = 1; s.regdst = 1; s.usesrt = 1; s.aluctl = ALU_ADD;
        s.rs = 8; s.rt = 9; s.rd = 10; s.rd1 = 5; s.rd2 = 7;
        s.mem_rw = 1; s.mem_rd = 8; s.mem_res = 100; s.wb_rw = 1; s.wb_rd = 8; s.wb_data = 200;
        step(s, 0, 0);
        check("add_a_mem", ALU_A, 32'd100);
        check("add_b", ALU_B, 32'd7);

        // $0 writes are never forwarded
        s = blank();
        s.valid = 1; s.regwrite = 1; s.regdst = 1; s.usesrt = 1; s.aluctl = ALU_OR;
        s.rs = 0; s.rt = 2; s.rd = 3; s.rd1 = 0; s.rd2 = 9;
        s.wb_rw = 1; s.wb_rd = 0; s.wb_data = 32'hFFFF;
        step(s, 0, 0);
        check("zero_nofwd", ALU_A, 32'd0);

        // SLL $x, $3, 4
        s = blank();
        s.valid = 1; s.regwrite = 1; s.regdst = 1; s.isshift = 1; s.usesrt = 1; s.aluctl = ALU_SLL;
        s.rs = 0; s.rt = 3; s.rd = 4; s.rd2 = 32'h1; s.shamt = 4;
        step(s, 0, 0);
        check("sll_a", ALU_A, 32'h1);
        check("sll_b", ALU_B, 32'd4);
        check("sll_ctl", {28'b0, ALUControl}, {28'b0, ALU_SLL});

        // LW $5, 16($1) then ADD using $5 -> hazard, flush clears it
        s = blank();
        s.valid = 1; s.regwrite = 1; s.memread = 1; s.memtoreg = 1; s.alusrc = 1; s.aluctl = ALU_ADD;
        s.rs = 1; s.rt = 5; s.rd = 0; s.imm = 16; s.rd1 = 32'h1000;
        step(s, 0, 0);
        s = blank();
        s.valid = 1; s.regwrite = 1; s.regdst = 1; s.usesrt = 1; s.aluctl = ALU_ADD;
        s.rs = 5; s.rt = 6; s.rd = 7;
        apply(s);
        #1;
        check("lu_hazard", {31'b0, LoadUseHazard}, 32'd1);
        step(s, 0, 1);

        // Hold for 3 cycles while ID changes, then Hold+Flush together
        s = blank();
        s.valid = 1; s.regwrite = 1; s.regdst = 1; s.usesrt = 1; s.aluctl = ALU_SUB;
        s.rs = 11; s.rt = 12; s.rd = 13; s.rd1 = 50; s.rd2 = 20;
        s.mem_rw = 1; s.mem_rd = 12; s.mem_res = 33;
        step(s, 0, 0);
        for (int i = 0; i < 3; i++) begin
            s.rs = 5'($urandom_range(1, 31)); s.rd1 = $urandom; s.rd2 = $urandom;
            s.aluctl = ALU_AND; s.memwrite = 1; s.rd = 5'($urandom_range(1, 31));
            step(s, 1, 0);
        end
        step(s, 1, 1);

        // ID bubble captured: controls gated to zero
        s = blank();
        s.valid = 0; s.regwrite = 1; s.memread = 1; s.memwrite = 1; s.memtoreg = 1;
        s.aluctl = ALU_NOR; s.rs = 4; s.rt = 6; s.rd = 8; s.rd1 = 3; s.rd2 = 4;
        step(s, 0, 0);

        // Randomised traffic over a small register window to provoke forwarding and hazards
        for (int i = 0; i < 24; i++) begin
            s = blank();
            s.valid = ($urandom_range(0, 5) != 0); s.regwrite = 1'($urandom);
            s.memread = 1'($urandom); s.memwrite = 1'($urandom); s.memtoreg = 1'($urandom);
            s.alusrc = 1'($urandom); s.regdst = 1'($urandom); s.isshift = 1'($urandom);
            s.usesrt = 1'($urandom); s.aluctl = 4'($urandom);
            s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
            s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
            s.rd = 5'($urandom_range(0, 3)); s.shamt = 5'($urandom);
            s.mem_rw = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 3)); s.mem_res = $urandom;
            s.wb_rw = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 3)); s.wb_data = $urandom;
            step(s, 0, 0);
        end

        // Asynchronous reset mid-run with a valid load in EX
        s = blank();
        s.valid = 1; s.regwrite = 1; s.memread = 1; s.alusrc = 1; s.aluctl = ALU_ADD;
        s.rs = 2; s.rt = 7; s.imm = 4;
        step(s, 0, 0);
        s.rs = 7;
        apply(s);
        #1;
        check("pre_rst_hazard", {31'b0, LoadUseHazard}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, EX_Valid}, 32'd0);
        check("mid_rst_regwrite", {31'b0, EX_RegWrite}, 32'd0);
        check("mid_rst_aluctl", {28'b0, ALUControl}, 32'd0);
        check("mid_rst_hazard", {31'b0, LoadUseHazard}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
